// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson ring generator:
// legal-code table, index lookup and direction encoding.
package johnson_pkg;

   localparam int JMAX_W = 64;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   function automatic int johnson_idxw(input int w);
      return $clog2(2 * w);
   endfunction

   // Code for index k: low k bits set up to k=w, then high bits clear from the bottom.
   function automatic logic [JMAX_W-1:0] johnson_code(
      input int w,
      input int k
   );
      logic [JMAX_W-1:0] c;
      c = '0;
      for (int i = 0; i < JMAX_W; i++) begin
         if (i < w) begin
            c[i] = (k <= w) ? (i < k) : (i >= k - w);
         end
      end
      return c;
   endfunction

   function automatic logic johnson_is_legal(
      input logic [JMAX_W-1:0] q,
      input int                w
   );
      logic hit;
      hit = 1'b0;
      for (int k = 0; k < 2 * JMAX_W; k++) begin
         if (k < 2 * w && q == johnson_code(w, k)) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   function automatic int johnson_index(
      input logic [JMAX_W-1:0] q,
      input int                w
   );
      int idx;
      idx = 0;
      for (int k = 0; k < 2 * JMAX_W; k++) begin
         if (k < 2 * w && q == johnson_code(w, k)) begin
            idx = k;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson ring state into
// legality, binary index and one-hot phase.
module johnson_decode
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDXW  = johnson_idxw(WIDTH)
) (
   input  logic [WIDTH-1:0]   q,
   output logic               legal,
   output logic [IDXW-1:0]    phase_idx,
   output logic [2*WIDTH-1:0] phase
);

   logic [JMAX_W-1:0] q_ext;
   int                idx;

   always_comb begin
      q_ext            = '0;
      q_ext[WIDTH-1:0] = q;
      legal            = johnson_is_legal(q_ext, WIDTH);
      idx              = 0;
      if (legal) begin
         idx = johnson_index(q_ext, WIDTH);
      end
      phase_idx = IDXW'(idx);
      phase     = '0;
      if (legal) begin
         phase = (2*WIDTH)'(1) << phase_idx;
      end
   end

endmodule

// File: rtl/johnson_ring_gen.sv
// Johnson ring sequencer: step, reverse, load,
// self-correction of illegal states, wrap/err pulses.
module johnson_ring_gen
   import johnson_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int IDXW  = johnson_idxw(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               dir,
   input  logic               load,
   input  logic [WIDTH-1:0]   load_val,
   output logic [WIDTH-1:0]   q,
   output logic [2*WIDTH-1:0] phase,
   output logic [IDXW-1:0]    phase_idx,
   output logic               wrap,
   output logic               err
);

   logic              legal;
   logic              ld_legal;
   logic [JMAX_W-1:0] lv_ext;
   logic [WIDTH-1:0]  q_nxt;
   logic              wrap_nxt;
   logic              err_nxt;

   johnson_decode #(
      .WIDTH (WIDTH),
      .IDXW  (IDXW)
   ) u_decode (
      .q         (q),
      .legal     (legal),
      .phase_idx (phase_idx),
      .phase     (phase)
   );

   always_comb begin
      lv_ext            = '0;
      lv_ext[WIDTH-1:0] = load_val;
      ld_legal          = johnson_is_legal(lv_ext, WIDTH);
      q_nxt             = q;
      wrap_nxt          = 1'b0;
      err_nxt           = 1'b0;
      if (load) begin
         if (ld_legal) begin
            q_nxt = load_val;
         end else begin
            q_nxt   = '0;
            err_nxt = 1'b1;
         end
      end else if (!legal) begin
         q_nxt   = '0;
         err_nxt = 1'b1;
      end else if (en) begin
         if (dir == DIR_REV) begin
            q_nxt    = {~q[0], q[WIDTH-1:1]};
            wrap_nxt = (phase_idx == '0);
         end else begin
            q_nxt    = {q[WIDTH-2:0], ~q[WIDTH-1]};
            wrap_nxt = (phase_idx == IDXW'(2*WIDTH-1));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= wrap_nxt;
         err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_johnson_ring_gen.sv
// Randomized bench with an index-level reference model
// for johnson_ring_gen at widths 4, 2, 5 and 8.
module tb_johnson_ring_gen;

   logic       clk = 1'b0;
   logic       reset, en, dir, load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic [7:0] phase;
   logic [2:0] phase_idx;
   logic       wrap, err;

   logic       rst_sw;
   logic       sw_one = 1'b1;
   logic       sw_zero = 1'b0;
   logic [1:0] lv2 = '0;
   logic [4:0] lv5 = '0;
   logic [7:0] lv8 = '0;
   logic [1:0] q2;
   logic [3:0] ph2;
   logic [1:0] pi2;
   logic [4:0] q5;
   logic [9:0] ph5;
   logic [3:0] pi5;
   logic [7:0] q8;
   logic [15:0] ph8;
   logic [3:0] pi8;
   logic       wr2, wr5, wr8, er2, er5, er8;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit chk_on = 0;

   // reference model state (index based)
   int   mk = 0;
   logic mwrap = 0;
   logic merr = 0;
   bit   mill = 0;
   int   swk[3];
   logic swwr[3];
   int   swlast[3];
   int   sww[3];

   always #5 clk = ~clk;

   johnson_ring_gen #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset), .en(en), .dir(dir),
      .load(load), .load_val(load_val), .q(q),
      .phase(phase), .phase_idx(phase_idx),
      .wrap(wrap), .err(err)
   );

   johnson_ring_gen #(.WIDTH(2)) dut2 (
      .clk(clk), .reset(rst_sw), .en(sw_one), .dir(sw_zero),
      .load(sw_zero), .load_val(lv2), .q(q2),
      .phase(ph2), .phase_idx(pi2), .wrap(wr2), .err(er2)
   );

   johnson_ring_gen #(.WIDTH(5)) dut5 (
      .clk(clk), .reset(rst_sw), .en(sw_one), .dir(sw_zero),
      .load(sw_zero), .load_val(lv5), .q(q5),
      .phase(ph5), .phase_idx(pi5), .wrap(wr5), .err(er5)
   );

   johnson_ring_gen #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(rst_sw), .en(sw_one), .dir(sw_zero),
      .load(sw_zero), .load_val(lv8), .q(q8),
      .phase(ph8), .phase_idx(pi8), .wrap(wr8), .err(er8)
   );

   function automatic logic [7:0] jcode(input int w, input int k);
      int v;
      if (k <= w) v = (1 << k) - 1;
      else v = ((1 << w) - 1) ^ ((1 << (k - w)) - 1);
      return 8'(v);
   endfunction

   function automatic int jfind(input int w, input logic [7:0] v);
      int r;
      r = -1;
      for (int k = 0; k < 2 * w; k++) if (jcode(w, k) == v) r = k;
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic chk_sw(input string nm, input int i,
                         input logic [7:0] qq, input logic [15:0] ph,
                         input logic [3:0] pi, input logic wr,
                         input logic er);
      check({nm, "_q"}, 32'(qq), 32'(jcode(sww[i], swk[i])));
      check({nm, "_phase"}, 32'(ph), 32'(1) << swk[i]);
      check({nm, "_onehot"}, 32'($onehot(ph)), 32'(1));
      check({nm, "_idx"}, 32'(pi), 32'(swk[i]));
      check({nm, "_wrap"}, 32'(wr), 32'(swwr[i]));
      check({nm, "_err"}, 32'(er), 32'(0));
      if (wr) begin
         if (swlast[i] >= 0) begin
            check({nm, "_period"}, 32'(cyc - swlast[i]), 32'(2 * sww[i]));
         end
         swlast[i] = cyc;
      end
   endtask

   // reference model advance on each rising edge
   always @(posedge clk) begin
      int j;
      if (reset) begin
         mk = 0; mwrap = 0; merr = 0; mill = 0;
      end else if (load) begin
         j = jfind(4, 8'(load_val));
         mwrap = 0; mill = 0;
         if (j >= 0) begin mk = j; merr = 0; end
         else begin mk = 0; merr = 1; end
      end else if (mill) begin
         mk = 0; merr = 1; mwrap = 0; mill = 0;
      end else if (en) begin
         merr = 0;
         if (dir) begin mwrap = (mk == 0); mk = (mk + 7) % 8; end
         else begin mwrap = (mk == 7); mk = (mk + 1) % 8; end
      end else begin
         mwrap = 0; merr = 0;
      end
      for (int i = 0; i < 3; i++) begin
         if (rst_sw) begin swk[i] = 0; swwr[i] = 0; end
         else begin
            swwr[i] = (swk[i] == 2 * sww[i] - 1);
            swk[i] = (swk[i] + 1) % (2 * sww[i]);
         end
      end
   end

   // single compare process, mid low phase
   always begin
      @(negedge clk);
      #2;
      if (chk_on) begin
         cyc++;
         check("q", 32'(q), mill ? 32'hA : 32'(jcode(4, mk)));
         check("phase", 32'(phase), mill ? 32'(0) : 32'(1) << mk);
         check("phase_idx", 32'(phase_idx), mill ? 32'(0) : 32'(mk));
         check("wrap", 32'(wrap), 32'(mwrap));
         check("err", 32'(err), 32'(merr));
         check("wrap_err_excl", 32'(wrap & err), 32'(0));
         chk_sw("w2", 0, 8'(q2), 16'(ph2), 4'(pi2), wr2, er2);
         chk_sw("w5", 1, 8'(q5), 16'(ph5), pi5, wr5, er5);
         chk_sw("w8", 2, q8, ph8, pi8, wr8, er8);
      end
   end

   logic [3:0] lit [9];
   logic       litw [9];

   initial begin
      lit  = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
      litw = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      sww = '{2, 5, 8};
      swk = '{0, 0, 0};
      swwr = '{0, 0, 0};
      swlast = '{-1, -1, -1};
      reset = 1; en = 1; dir = 0; load = 0; load_val = 0; rst_sw = 1;
      @(posedge clk);
      chk_on = 1;
      @(posedge clk);
      @(negedge clk);
      reset = 0; rst_sw = 0;
      for (int i = 0; i < 9; i++) begin
         if (i > 0) @(negedge clk);
         check("seq_q", 32'(q), 32'(lit[i]));
         check("seq_idx", 32'(phase_idx), 32'(i % 8));
         check("seq_wrap", 32'(wrap), 32'(litw[i]));
      end
      dir = 1;
      @(negedge clk);
      check("rev_q8", 32'(q), 32'h8);
      check("rev_wrap", 32'(wrap), 32'(1));
      @(negedge clk);
      check("rev_qC", 32'(q), 32'hC);
      @(negedge clk);
      check("rev_qE", 32'(q), 32'hE);
      for (int i = 0; i < 4; i++) begin
         dir = ~dir;
         @(negedge clk);
         check("toggle_q", 32'(q), (i % 2 == 0) ? 32'hC : 32'hE);
      end
      load = 1; load_val = 4'h7; en = 1;
      @(negedge clk);
      check("load_q", 32'(q), 32'h7);
      check("load_phase", 32'(phase), 32'h08);
      check("load_err", 32'(err), 32'(0));
      load_val = 4'h5;
      @(negedge clk);
      check("badload_q", 32'(q), 32'h0);
      check("badload_err", 32'(err), 32'(1));
      load = 0; en = 0;
      @(negedge clk);
      check("hold_err", 32'(err), 32'(0));
      force dut.q = 4'hA;
      mill = 1;
      #2;
      check("upset_phase", 32'(phase), 32'(0));
      check("upset_idx", 32'(phase_idx), 32'(0));
      #1;
      release dut.q;
      @(negedge clk);
      check("fix_q", 32'(q), 32'h0);
      check("fix_err", 32'(err), 32'(1));
      check("fix_wrap", 32'(wrap), 32'(0));
      en = 1; dir = 0;
      repeat (5) @(negedge clk);
      check("mid_qE", 32'(q), 32'hE);
      reset = 1; load = 1; load_val = 4'h3;
      @(negedge clk);
      check("rst_q", 32'(q), 32'h0);
      check("rst_wrap", 32'(wrap), 32'(0));
      check("rst_err", 32'(err), 32'(0));
      reset = 0; load = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 49) == 0);
         load = ($urandom_range(0, 7) == 0);
         load_val = 4'($urandom);
         en = ($urandom_range(0, 3) != 0);
         dir = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 39) == 0) begin
            force dut.q = 4'hA;
            mill = 1;
            #3;
            release dut.q;
         end
      end
      @(negedge clk);
      reset = 0; load = 0; en = 0;
      repeat (2) @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
